// File: rtl/johnson_monitor.sv
// ---------------------------------------------------------------------------
// johnson_monitor
//
// Downstream consumer of a 3-bit Johnson counter. Samples the counter's code
// on the rising edge, decodes it into a registered one-hot 6-phase output and
// a phase index, checks every step against the legal Johnson sequence, flags
// illegal codes and sequence errors, asserts lock after LOCK_COUNT
// consecutive valid steps and counts completed revolutions (5 -> 0 steps).
//
// Parameters:
//   LOCK_COUNT   consecutive valid steps needed for o_locked (1..15)
//   REV_W        width of the revolution counter
//
// Ports:
//   i_clk        clock, all state updates on the rising edge
//   i_rst        synchronous active-high reset
//   i_q          Johnson code from the counter (bit 2 = first stage)
//   i_clr_err    clears sticky o_seq_err (a same-edge error wins)
//   o_phase      one-hot decoded phase, bit n = phase n, 0 on illegal code
//   o_phase_idx  phase index 0..5, 7 on illegal code
//   o_illegal    current sample is an illegal code (010 or 101)
//   o_seq_err    sticky: illegal code or bad step since last clear
//   o_locked     LOCK_COUNT consecutive valid steps seen
//   o_rev_cnt    completed revolutions, modulo 2^REV_W
//   o_rev_pulse  one-cycle pulse on each completed revolution
// ---------------------------------------------------------------------------
module johnson_monitor #(
    parameter int unsigned LOCK_COUNT = 6,
    parameter int unsigned REV_W      = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [2:0]       i_q,
    input  logic             i_clr_err,
    output logic [5:0]       o_phase,
    output logic [2:0]       o_phase_idx,
    output logic             o_illegal,
    output logic             o_seq_err,
    output logic             o_locked,
    output logic [REV_W-1:0] o_rev_cnt,
    output logic             o_rev_pulse
);

    localparam logic [3:0] LOCK_MAX = 4'(LOCK_COUNT);
    localparam logic [2:0] IDX_BAD  = 3'd7;

    typedef enum logic [1:0] {
        S_INIT,
        S_ACQ,
        S_LOCK
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] good_cnt;
    logic [3:0] good_next;
    logic [2:0] r_prev;

    logic [2:0] cur_idx;
    logic [2:0] prev_idx;
    logic [2:0] prev_succ;
    logic       cur_legal;
    logic       prev_legal;
    logic       valid_step;
    logic       err_event;
    logic       rev_step;

    logic [5:0]       phase_next;
    logic [2:0]       idx_next;
    logic             illegal_next;
    logic             seq_err_next;
    logic             locked_next;
    logic [REV_W-1:0] rev_cnt_next;
    logic             rev_pulse_next;

    function automatic logic [2:0] decode(input logic [2:0] q);
        case (q)
            3'b000:  decode = 3'd0;
            3'b100:  decode = 3'd1;
            3'b110:  decode = 3'd2;
            3'b111:  decode = 3'd3;
            3'b011:  decode = 3'd4;
            3'b001:  decode = 3'd5;
            default: decode = IDX_BAD;
        endcase
    endfunction

    // Step classification against the previous sample
    always_comb begin
        cur_idx    = decode(i_q);
        prev_idx   = decode(r_prev);
        cur_legal  = (cur_idx != IDX_BAD);
        prev_legal = (prev_idx != IDX_BAD);
        prev_succ  = (prev_idx == 3'd5) ? 3'd0 : prev_idx + 3'd1;
        valid_step = prev_legal && cur_legal && (cur_idx == prev_succ);
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_INIT;
            good_cnt    <= '0;
            r_prev      <= '0;
            o_phase     <= '0;
            o_phase_idx <= '0;
            o_illegal   <= 1'b0;
            o_seq_err   <= 1'b0;
            o_locked    <= 1'b0;
            o_rev_cnt   <= '0;
            o_rev_pulse <= 1'b0;
        end else begin
            state       <= state_next;
            good_cnt    <= good_next;
            r_prev      <= i_q;
            o_phase     <= phase_next;
            o_phase_idx <= idx_next;
            o_illegal   <= illegal_next;
            o_seq_err   <= seq_err_next;
            o_locked    <= locked_next;
            o_rev_cnt   <= rev_cnt_next;
            o_rev_pulse <= rev_pulse_next;
        end
    end

    // Next-state logic; err_event marks any illegal code or bad step
    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        err_event  = 1'b0;
        case (state)
            S_INIT: begin
                // No valid previous sample yet, so no step check here
                if (cur_legal) begin
                    state_next = S_ACQ;
                    good_next  = '0;
                end else begin
                    err_event = 1'b1;
                end
            end
            S_ACQ: begin
                if (!cur_legal) begin
                    state_next = S_INIT;
                    good_next  = '0;
                    err_event  = 1'b1;
                end else if (valid_step) begin
                    if (good_cnt + 4'd1 >= LOCK_MAX) begin
                        good_next  = LOCK_MAX;
                        state_next = S_LOCK;
                    end else begin
                        good_next = good_cnt + 4'd1;
                    end
                end else begin
                    good_next = '0;
                    err_event = 1'b1;
                end
            end
            S_LOCK: begin
                if (!cur_legal) begin
                    state_next = S_INIT;
                    good_next  = '0;
                    err_event  = 1'b1;
                end else if (!valid_step) begin
                    state_next = S_ACQ;
                    good_next  = '0;
                    err_event  = 1'b1;
                end
            end
            default: begin
                state_next = S_INIT;
                good_next  = '0;
            end
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        // A valid step out of phase 5 necessarily lands on phase 0
        rev_step       = valid_step && (state != S_INIT) && (prev_idx == 3'd5);
        phase_next     = cur_legal ? (6'd1 << cur_idx) : '0;
        idx_next       = cur_idx;
        illegal_next   = !cur_legal;
        seq_err_next   = err_event | (o_seq_err & ~i_clr_err);
        locked_next    = (state_next == S_LOCK);
        rev_cnt_next   = rev_step ? o_rev_cnt + REV_W'(1) : o_rev_cnt;
        rev_pulse_next = rev_step;
    end

endmodule

// File: tb/tb_johnson_monitor.sv
module tb_johnson_monitor;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [2:0] i_q = 3'b000;
    logic       i_clr_err = 1'b0;

    logic [5:0] o_phase,     p2;
    logic [2:0] o_phase_idx, x2;
    logic       o_illegal,   il2;
    logic       o_seq_err,   se2;
    logic       o_locked,    lk2;
    logic [7:0] o_rev_cnt;
    logic [1:0] rc2;
    logic       o_rev_pulse, rp2;

    int checks = 0;
    int errors = 0;

    logic [2:0] jc [6];
    logic [12:0] obs;

    always #5 clk = ~clk;

    johnson_monitor #(.LOCK_COUNT(6), .REV_W(8)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_q(i_q), .i_clr_err(i_clr_err),
        .o_phase(o_phase), .o_phase_idx(o_phase_idx), .o_illegal(o_illegal),
        .o_seq_err(o_seq_err), .o_locked(o_locked), .o_rev_cnt(o_rev_cnt),
        .o_rev_pulse(o_rev_pulse)
    );

    johnson_monitor #(.LOCK_COUNT(6), .REV_W(2)) dut_w2 (
        .i_clk(clk), .i_rst(i_rst), .i_q(i_q), .i_clr_err(i_clr_err),
        .o_phase(p2), .o_phase_idx(x2), .o_illegal(il2),
        .o_seq_err(se2), .o_locked(lk2), .o_rev_cnt(rc2),
        .o_rev_pulse(rp2)
    );

    assign obs = {o_phase, o_phase_idx, o_illegal, o_seq_err, o_locked, o_rev_pulse};

    // Expected {phase, idx, illegal, seq_err, locked, rev_pulse} for a legal code
    function automatic logic [12:0] exp_vec(input int idx, input logic err,
                                           input logic lck, input logic pls);
        logic [5:0] ph;
        ph = 6'd1 << idx;
        return {ph, 3'(idx), 1'b0, err, lck, pls};
    endfunction

    task automatic tick(input logic [2:0] q, input logic clr);
        @(negedge clk);
        i_q       = q;
        i_clr_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick(3'b000, 1'b0);
        tick(3'b000, 1'b0);
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", obs, 13'd0);
        end
        checks++;
        if (o_rev_cnt !== 8'd0 || rc2 !== 2'd0) begin
            errors++;
            $display("FAIL reset_rev_cnt: got %0d/%0d expected 0/0", o_rev_cnt, rc2);
        end
    endtask

    task automatic test_run();
        logic [12:0] e;
        i_rst = 1'b0;
        for (int k = 0; k < 14; k++) begin
            tick(jc[k % 6], 1'b0);
            e = exp_vec(k % 6, 1'b0, k >= 6, (k > 0) && (k % 6 == 0));
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL run_step%0d: got %h expected %h", k, obs, e);
            end
            checks++;
            if (o_rev_cnt !== 8'(k / 6)) begin
                errors++;
                $display("FAIL run_rev_cnt%0d: got %0d expected %0d", k, o_rev_cnt, k / 6);
            end
        end
    endtask

    // Entered locked at phase 1
    task automatic test_illegal();
        logic [12:0] e;
        int idx;
        tick(3'b010, 1'b0);
        e = {6'b000000, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL illegal_code: got %h expected %h", obs, e);
        end
        // Re-entry sample at phase 2, then six valid steps to relock
        for (int j = 0; j < 7; j++) begin
            idx = (2 + j) % 6;
            tick(jc[idx], 1'b0);
            e = exp_vec(idx, 1'b1, j == 6, (j > 0) && (idx == 0));
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL illegal_resume%0d: got %h expected %h", j, obs, e);
            end
        end
        checks++;
        if (o_rev_cnt !== 8'd3) begin
            errors++;
            $display("FAIL illegal_rev_cnt: got %0d expected 3", o_rev_cnt);
        end
    endtask

    // Locked at phase 2
    task automatic test_clear();
        logic [12:0] e;
        tick(jc[3], 1'b1);
        e = exp_vec(3, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL clear_no_err: got %h expected %h", obs, e);
        end
    endtask

    // Locked at phase 3
    task automatic test_stall_skip();
        logic [12:0] e;
        int idx;
        for (int j = 0; j < 5; j++) begin
            idx = (4 + j) % 6;
            tick(jc[idx], 1'b0);
            e = exp_vec(idx, 1'b0, 1'b1, idx == 0);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL stall_pre%0d: got %h expected %h", j, obs, e);
            end
        end
        // Hold 110 with clear on the same edge: error must win
        tick(jc[2], 1'b1);
        e = exp_vec(2, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL stall_hold_clr: got %h expected %h", obs, e);
        end
        // Skip 110 -> 011
        tick(jc[4], 1'b0);
        e = exp_vec(4, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL skip: got %h expected %h", obs, e);
        end
        // Still acquiring with zero count: lock exactly on the 6th valid step
        for (int j = 1; j <= 6; j++) begin
            idx = (4 + j) % 6;
            tick(jc[idx], 1'b0);
            e = exp_vec(idx, 1'b1, j == 6, idx == 0);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL skip_relock%0d: got %h expected %h", j, obs, e);
            end
        end
        tick(jc[5], 1'b1);
        e = exp_vec(5, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL clear_after_relock: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_reset_mid_and_wrap();
        logic [12:0] e;
        logic [1:0]  exp2 [5];
        int          n;
        exp2 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        n = 0;
        checks++;
        if (o_locked !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_locked: got %b expected 1", o_locked);
        end
        i_rst = 1'b1;
        tick(3'b000, 1'b0);
        checks++;
        if (obs !== 13'd0 || o_rev_cnt !== 8'd0 || rc2 !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset: got %h/%0d/%0d expected 0/0/0", obs, o_rev_cnt, rc2);
        end
        i_rst = 1'b0;
        for (int k = 0; k < 31; k++) begin
            tick(jc[k % 6], 1'b0);
            e = exp_vec(k % 6, 1'b0, k >= 6, (k > 0) && (k % 6 == 0));
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reacq_step%0d: got %h expected %h", k, obs, e);
            end
            if (k > 0 && k % 6 == 0) begin
                checks++;
                if (rp2 !== 1'b1 || rc2 !== exp2[n] || se2 !== 1'b0) begin
                    errors++;
                    $display("FAIL wrap_rev%0d: got pulse=%b cnt=%0d err=%b expected 1/%0d/0",
                             n, rp2, rc2, se2, exp2[n]);
                end
                n++;
            end
        end
        checks++;
        if (o_rev_cnt !== 8'd5) begin
            errors++;
            $display("FAIL reacq_rev_cnt: got %0d expected 5", o_rev_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        jc = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b011, 3'b001};
        test_reset();
        test_run();
        test_illegal();
        test_clear();
        test_stall_skip();
        test_reset_mid_and_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
